// File: rtl/gf180mcu_osu_sc_gp9t3v3__dlatpipe.sv
// -----------------------------------------------------------------------------
// gf180mcu_osu_sc_gp9t3v3__dlatpipe
//
// WIDTH-bit, DEPTH-stage enabled register pipeline with a valid tag per stage.
// It retimes a data/valid channel for datapath delay matching. The pipeline
// has three modes of operation:
//   - Hold:    when EN is low, every stage keeps its contents.
//   - Bypass:  when BYP is high, the outputs follow the inputs combinationally.
//   - Count:   CNT is a registered count of how many stages hold a valid entry.
//
// Optional feature (compile-time macro DLATPIPE_PARITY_EN):
//   Each stage carries a parity bit. PINJ corrupts the parity of the entry
//   being loaded. PERR flags a parity mismatch on a valid output entry.
//   When the macro is undefined, PINJ, PERR and the parity state do not exist.
//
// Parameters:
//   WIDTH      data bits per stage (>=1)
//   DEPTH      number of pipeline stages (>=1)
//   RESET_VAL  value loaded into every data stage on reset
//
// Ports:
//   CLK   in   1                clock; all state updates on the rising edge
//   R     in   1                synchronous active-high reset (has priority over EN)
//   D     in   WIDTH            data in
//   DV    in   1                data valid in
//   EN    in   1                advance enable; 0 = every stage holds
//   BYP   in   1                bypass: Q/QV follow D/DV with zero latency
//   PINJ  in   1                parity-error injection (DLATPIPE_PARITY_EN only)
//   Q     out  WIDTH            data out
//   QV    out  1                valid out
//   CNT   out  clog2(DEPTH+1)   registered count of valid stages
//   PERR  out  1                parity error on output stage (DLATPIPE_PARITY_EN only)
// -----------------------------------------------------------------------------
module gf180mcu_osu_sc_gp9t3v3__dlatpipe #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         CLK,
   input  logic                         R,
   input  logic [WIDTH-1:0]             D,
   input  logic                         DV,
   input  logic                         EN,
   input  logic                         BYP,
`ifdef DLATPIPE_PARITY_EN
   input  logic                         PINJ,
   output logic                         PERR,
`endif
   output logic [WIDTH-1:0]             Q,
   output logic                         QV,
   output logic [$clog2(DEPTH+1)-1:0]   CNT
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   // Stage storage. Index 0 is the entry stage and DEPTH-1 is the output stage.
   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [DEPTH-1:0] stage_vld;
   logic [CNT_W-1:0] occ_cnt;

   // Occupancy update for one advance. One valid may enter and one may leave.
   // Simultaneous entry and exit leaves the count unchanged.
   // The count cannot exceed DEPTH: entry without exit implies a free stage.
   // The count cannot underflow: exit implies a valid stage is present.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic             vin,
                                                  input logic             vout);
      logic [CNT_W-1:0] res;
      res = cnt;
      if (vin && !vout)
         res = cnt + CNT_W'(1);
      else if (!vin && vout)
         res = cnt - CNT_W'(1);
      return res;
   endfunction

`ifdef DLATPIPE_PARITY_EN
   function automatic logic parity_of(input logic [WIDTH-1:0] val);
      return ^val;
   endfunction

   logic [DEPTH-1:0] stage_par;
`endif

   // ---- stage registers: shift on EN, reset clears valids and count ----
   always_ff @(posedge CLK) begin
      if (R) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_data[i] <= RESET_VAL;
         end
         stage_vld <= '0;
         occ_cnt   <= '0;
      end else if (EN) begin
         stage_data[0] <= D;
         stage_vld[0]  <= DV;
         for (int i = 1; i < DEPTH; i++) begin
            stage_data[i] <= stage_data[i-1];
            stage_vld[i]  <= stage_vld[i-1];
         end
         occ_cnt <= cnt_next(occ_cnt, DV, stage_vld[DEPTH-1]);
      end
   end

`ifdef DLATPIPE_PARITY_EN
   // ---- parity stages travel in lockstep with the data stages ----
   always_ff @(posedge CLK) begin
      if (R) begin
         stage_par <= {DEPTH{parity_of(RESET_VAL)}};
      end else if (EN) begin
         stage_par[0] <= parity_of(D) ^ PINJ;
         for (int i = 1; i < DEPTH; i++) begin
            stage_par[i] <= stage_par[i-1];
         end
      end
   end
`endif

   // ---- output mux: bypass affects outputs only, never stage state ----
   always_comb begin
      Q   = stage_data[DEPTH-1];
      QV  = stage_vld[DEPTH-1];
      CNT = occ_cnt;
      if (BYP) begin
         Q  = D;
         QV = DV;
      end
   end

`ifdef DLATPIPE_PARITY_EN
   always_comb begin
      PERR = 1'b0;
      if (!BYP && stage_vld[DEPTH-1])
         PERR = (parity_of(stage_data[DEPTH-1]) != stage_par[DEPTH-1]);
   end
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__dlatpipe.sv
module tb_gf180mcu_osu_sc_gp9t3v3__dlatpipe;
   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         r, dv, en, byp, pinj;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         qv;
   logic [2:0]   cnt;
   logic         perr;

   always #5 clk = ~clk;

   gf180mcu_osu_sc_gp9t3v3__dlatpipe #(.WIDTH(W), .DEPTH(N), .RESET_VAL(8'h00)) dut (
      .CLK (clk),
      .R   (r),
      .D   (d),
      .DV  (dv),
      .EN  (en),
      .BYP (byp),
`ifdef DLATPIPE_PARITY_EN
      .PINJ(pinj),
      .PERR(perr),
`endif
      .Q   (q),
      .QV  (qv),
      .CNT (cnt)
   );
`ifndef DLATPIPE_PARITY_EN
   assign perr = 1'b0;
`endif

   // Reference model: the pipeline is a fixed-length queue of entries, newest first.
   typedef struct packed {logic [W-1:0] d; logic v; logic p;} ent_t;
   typedef struct packed {logic [W-1:0] q; logic qv; logic [2:0] cnt; logic perr;} exp_t;

   ent_t pipe[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic int occupancy();
      int n = 0;
      foreach (pipe[i]) n += int'(pipe[i].v);
      return n;
   endfunction

   task automatic reset_model();
      pipe.delete();
      repeat (N) pipe.push_back('{d: 8'h00, v: 1'b0, p: 1'b0});
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // One clock cycle of stimulus: drive inputs, record the expected outputs for
   // this cycle, then advance the model as the coming rising edge will.
   task automatic step(input logic r_i, input logic en_i, input logic dv_i,
                       input logic byp_i, input logic [W-1:0] d_i, input logic pinj_i);
      exp_t e;
      ent_t last;
      @(posedge clk);
      #1;
      r = r_i; en = en_i; dv = dv_i; byp = byp_i; d = d_i; pinj = pinj_i;
      last   = pipe[N-1];
      e.q    = byp_i ? d_i  : last.d;
      e.qv   = byp_i ? dv_i : last.v;
      e.cnt  = 3'(occupancy());
      e.perr = !byp_i && last.v && ((^last.d) != last.p);
      sb.push_back(e);
      if (r_i) begin
         reset_model();
      end else if (en_i) begin
         pipe.push_front('{d: d_i, v: dv_i, p: (^d_i) ^ pinj_i});
         void'(pipe.pop_back());
      end
   endtask

   // Monitor: checks the outputs each cycle, mid-cycle, against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("Q", q, e.q);
            chk("QV", {7'd0, qv}, {7'd0, e.qv});
            chk("CNT", {5'd0, cnt}, {5'd0, e.cnt});
`ifdef DLATPIPE_PARITY_EN
            chk("PERR", {7'd0, perr}, {7'd0, e.perr});
`endif
         end
      end
   end

   initial begin
      logic [W-1:0] fill [4];
      fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
      r = 1'b1; en = 1'b0; dv = 1'b0; byp = 1'b0; d = '0; pinj = 1'b0;
      repeat (2) @(posedge clk);
      reset_model();

      // Reset state, then reset that also has EN=1 and DV=1.
      step(1, 0, 0, 0, 8'h00, 0);
      step(1, 1, 1, 0, 8'hFF, 0);
      step(0, 0, 0, 0, 8'h00, 0);

      // Fill sequence, then drain with DV=0.
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, fill[i], 0);
      repeat (5) step(0, 1, 0, 0, 8'h00, 0);

      // Load one entry, hold for three cycles, then resume advancing.
      step(0, 1, 1, 0, 8'hA5, 0);
      repeat (3) step(0, 0, 1, 0, 8'hEE, 0);
      repeat (5) step(0, 1, 0, 0, 8'h00, 0);

      // Bypass while the pipeline keeps advancing, then drop bypass.
      step(0, 1, 1, 1, 8'h5A, 0);
      step(0, 1, 1, 1, 8'h6B, 0);
      step(0, 1, 0, 1, 8'h7C, 0);
      repeat (3) step(0, 1, 0, 0, 8'h00, 0);

      // Full pipeline, reset mid-stream, then confirm no stale valid emerges.
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, fill[i] ^ 8'hF0, 0);
      step(1, 1, 1, 0, 8'h99, 0);
      repeat (5) step(0, 1, 0, 0, 8'h00, 0);

      // Parity entry with and without injection.
      step(0, 1, 1, 0, 8'h03, 1);
      repeat (4) step(0, 1, 0, 0, 8'h00, 0);
      step(0, 1, 1, 0, 8'h03, 0);
      repeat (4) step(0, 1, 0, 0, 8'h00, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom),
              ($urandom_range(0, 5) == 0));
      end

      step(0, 0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
